// File: rtl/cacheline_burst_adaptor.sv
// Converts one cacheline fill or writeback into a fixed-length burst of
// narrow memory beats. The cache side sees a single request and a single response pulse.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic [LINE_WIDTH-1:0] r_line_out;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [BEAT_WIDTH-1:0] r_burst;
  logic [31:0]           r_addr;
  logic                  r_read;
  logic                  r_write;
  logic                  r_resp;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [CW-1:0]         w_count_inc;
  logic [LINE_WIDTH-1:0] w_line_out_nxt;
  logic [LINE_WIDTH-1:0] w_wline_nxt;
  logic [BEAT_WIDTH-1:0] w_burst_nxt;
  logic [31:0]           w_addr_nxt;
  logic                  w_read_nxt;
  logic                  w_write_nxt;
  logic                  w_resp_nxt;

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_line_out <= '0;
      r_wline    <= '0;
      r_burst    <= '0;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_resp     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_line_out <= w_line_out_nxt;
      r_wline    <= w_wline_nxt;
      r_burst    <= w_burst_nxt;
      r_addr     <= w_addr_nxt;
      r_read     <= w_read_nxt;
      r_write    <= w_write_nxt;
      r_resp     <= w_resp_nxt;
    end
  end

  // The beat count saturates at the last beat; only DONE returns it to zero.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_line_out_nxt = r_line_out;
    w_wline_nxt    = r_wline;
    w_burst_nxt    = r_burst;
    w_addr_nxt     = r_addr;
    w_read_nxt     = r_read;
    w_write_nxt    = r_write;
    w_resp_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_i) begin
          w_addr_nxt  = address_i & ALIGN_MASK;
          w_read_nxt  = 1'b1;
          w_state_nxt = RD;
        end else if (write_i) begin
          w_addr_nxt  = address_i & ALIGN_MASK;
          w_wline_nxt = line_i;
          w_burst_nxt = line_i[BEAT_WIDTH-1:0];
          w_write_nxt = 1'b1;
          w_state_nxt = WR;
        end
      end
      RD: begin
        if (resp_i) begin
          w_line_out_nxt[r_count*BEAT_WIDTH +: BEAT_WIDTH] = burst_i;
          if (r_count == LAST_BEAT) begin
            w_read_nxt  = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          if (r_count == LAST_BEAT) begin
            w_write_nxt = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = w_count_inc;
            w_burst_nxt = r_wline[w_count_inc*BEAT_WIDTH +: BEAT_WIDTH];
          end
        end
      end
      DONE: begin
        w_resp_nxt  = 1'b1;
        w_count_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign line_o    = r_line_out;
  assign burst_o   = r_burst;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

endmodule
